// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot key capture block.
// Holds the FSM state encoding and the one-hot test/priority helpers.
// Helpers operate on MAX_W-bit vectors; callers zero-extend narrower buses.
package onehot_pkg;

    // Widest key bus the helper functions handle.
    localparam int MAX_W = 64;

    // State encoding of the capture FSM.
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = IDLE,
        S_SETTLE  = SETTLE,
        S_HOLD    = HOLD,
        S_RELEASE = RELEASE
    } state_e;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [MAX_W-1:0] v);
        return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
    endfunction

    // Isolates the lowest-index set bit of v (zero stays zero).
    function automatic logic [MAX_W-1:0] lowest_bit(input logic [MAX_W-1:0] v);
        return v & (~v + MAX_W'(1));
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
// Latency: 2 clk_i cycles from input sample to q_o.
// No backpressure; bits are synchronized independently (no bus coherence).
module sync_2ff #(
    parameter int WIDTH_P = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [WIDTH_P-1:0] d_i,
    output logic [WIDTH_P-1:0] q_o
);

    logic [WIDTH_P-1:0] meta_q;
    logic [WIDTH_P-1:0] sync_q;

    // Both stages clear asynchronously so no stale key survives reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/onehot_capture.sv
// Debounces raw key lines and captures a single pressed key as a one-hot code.
// Latency: press accepted DEBOUNCE_CYCLES_P+3 edges after keys settle; release likewise.
// No backpressure: valid_o is a one-cycle pulse, downstream must take it when seen.
// Optional ONEHOT_CAPTURE_PRIORITY_EN: multi-key presses resolve to the lowest-index
// key (flagged on multi_o) instead of being rejected.
module onehot_capture
    import onehot_pkg::*;
#(
    parameter int WIDTH_P           = 10,   // at most MAX_W
    parameter int DEBOUNCE_CYCLES_P = 16    // 2 or more
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [WIDTH_P-1:0] keys_i,
    output logic [WIDTH_P-1:0] one_hot_o,
    output logic               valid_o,
    output logic               held_o,
    output logic               multi_o
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES_P);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES_P - 1);

    logic [WIDTH_P-1:0] sync_w;
    logic               sync_nz_w;
    logic               cand_onehot_w;

    state_e             state_q;
    logic [WIDTH_P-1:0] cand_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH_P-1:0] one_hot_q;
    logic               valid_q;
    logic               held_q;
    logic               multi_q;

    sync_2ff #(
        .WIDTH_P (WIDTH_P)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (keys_i),
        .q_o    (sync_w)
    );

    assign sync_nz_w     = |sync_w;
    assign cand_onehot_w = is_onehot(MAX_W'(cand_q));

    // Capture FSM: every output is registered here; held_q always tracks |one_hot_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            one_hot_q <= '0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (sync_nz_w) begin
                        cand_q  <= sync_w;
                        cnt_q   <= '0;
                        state_q <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (!sync_nz_w) begin
                        // Key let go before it was stable: a glitch, drop it.
                        state_q <= S_IDLE;
                    end else if (sync_w != cand_q) begin
                        // Pattern changed: restart the stability timer on the new one.
                        cand_q <= sync_w;
                        cnt_q  <= '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (cand_onehot_w) begin
                        one_hot_q <= cand_q;
                        held_q    <= 1'b1;
                        valid_q   <= 1'b1;
                        state_q   <= S_HOLD;
                    end else begin
`ifdef ONEHOT_CAPTURE_PRIORITY_EN
                        // Several keys stable together: lowest index wins.
                        one_hot_q <= WIDTH_P'(lowest_bit(MAX_W'(cand_q)));
                        held_q    <= 1'b1;
                        valid_q   <= 1'b1;
                        multi_q   <= 1'b1;
                        state_q   <= S_HOLD;
`else
                        // Several keys stable together: reject, wait for full release.
                        multi_q <= 1'b1;
                        state_q <= S_RELEASE;
`endif
                    end
                end

                S_HOLD: begin
                    // Code stays frozen; only an all-keys-up starts the release timer.
                    if (!sync_nz_w) begin
                        cnt_q   <= '0;
                        state_q <= S_RELEASE;
                    end
                end

                S_RELEASE: begin
                    if (sync_nz_w) begin
                        cnt_q <= '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        one_hot_q <= '0;
                        held_q    <= 1'b0;
                        multi_q   <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign one_hot_o = one_hot_q;
    assign valid_o   = valid_q;
    assign held_o    = held_q;
    assign multi_o   = multi_q;

endmodule

// File: tb/tb_onehot_capture.sv
// Bench for onehot_capture: directed scenarios then random key patterns,
// every cycle checked against a run-length based reference model.
`timescale 1ns/1ps
module tb_onehot_capture;

    localparam int W = 10;
    localparam int D = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] keys;
    logic [W-1:0] one_hot_o;
    logic         valid_o;
    logic         held_o;
    logic         multi_o;

    int tests = 0;
    int fails = 0;

    onehot_capture #(
        .WIDTH_P           (W),
        .DEBOUNCE_CYCLES_P (D)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .keys_i    (keys),
        .one_hot_o (one_hot_o),
        .valid_o   (valid_o),
        .held_o    (held_o),
        .multi_o   (multi_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phases with run-length counting.
    logic [W-1:0] m_s1, m_s2, m_cand, m_oh;
    logic         m_valid, m_multi;
    int           m_phase;      // 0 waiting, 1 settling, 2 holding, 3 releasing
    int           m_seen;       // consecutive edges the candidate was seen
    int           m_zero_need;  // zero edges still needed to finish release
    logic         prev_valid;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_cand = '0; m_oh = '0;
        m_valid = 1'b0; m_multi = 1'b0;
        m_phase = 0; m_seen = 0; m_zero_need = 0;
        prev_valid = 1'b0;
    endtask

    task automatic accept_press();
        if ($countones(m_cand) == 1) begin
            m_oh = m_cand; m_valid = 1'b1; m_phase = 2;
        end else begin
`ifdef ONEHOT_CAPTURE_PRIORITY_EN
            logic found;
            found = 1'b0;
            m_oh = '0;
            for (int i = 0; i < W; i++) begin
                if (!found && m_cand[i]) begin
                    m_oh[i] = 1'b1;
                    found = 1'b1;
                end
            end
            m_valid = 1'b1; m_multi = 1'b1; m_phase = 2;
`else
            m_multi = 1'b1; m_phase = 3; m_zero_need = 1;
`endif
        end
    endtask

    task automatic model_edge(input logic [W-1:0] k);
        logic [W-1:0] s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s = m_s2; m_s2 = m_s1; m_s1 = k;
        m_valid = 1'b0;
        case (m_phase)
            0: if (s != 0) begin m_cand = s; m_seen = 1; m_phase = 1; end
            1: begin
                if (s == 0) m_phase = 0;
                else if (s != m_cand) begin m_cand = s; m_seen = 1; end
                else begin
                    m_seen++;
                    if (m_seen == D + 1) accept_press();
                end
            end
            2: if (s == 0) begin m_phase = 3; m_zero_need = D; end
            default: begin
                if (s != 0) m_zero_need = D;
                else begin
                    m_zero_need--;
                    if (m_zero_need == 0) begin
                        m_oh = '0; m_multi = 1'b0; m_phase = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("one_hot", one_hot_o, m_oh);
        chk("valid", W'(valid_o), W'(m_valid));
        chk("held", W'(held_o), W'(|m_oh));
        chk("multi", W'(multi_o), W'(m_multi));
        chk("valid_not_back_to_back", W'(valid_o & prev_valid), W'(0));
        prev_valid = valid_o;
    endtask

    // One clock: drive keys, model the edge, check #1 after it, return at negedge.
    task automatic step(input logic [W-1:0] k);
        keys = k;
        @(posedge clk);
        model_edge(k);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic steps(input logic [W-1:0] k, input int n);
        for (int i = 0; i < n; i++) step(k);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        for (int i = 0; i < n; i++) step(keys);
        rst_n = 1'b1;
    endtask

    // Edge number (1-based) at which valid_o first rises, 0 if never within n edges.
    task automatic edges_to_valid(input logic [W-1:0] k, input int n, output int e_out);
        e_out = 0;
        for (int e = 1; e <= n; e++) begin
            step(k);
            if (valid_o === 1'b1 && e_out == 0) e_out = e;
        end
    endtask

    task automatic edges_to_clear(input int n, output int e_out);
        e_out = 0;
        for (int e = 1; e <= n; e++) begin
            step('0);
            if (one_hot_o === '0 && e_out == 0) e_out = e;
        end
    endtask

    initial begin
        int e;
        logic [W-1:0] v;
        keys  = '0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset(3);
        steps('0, 2);

        // Steady single key: accepted on edge D+3.
        edges_to_valid(10'h004, 10, e);
        chk("press_latency", W'(e), W'(D + 3));
        chk("press_code", one_hot_o, 10'h004);
        edges_to_clear(10, e);
        chk("release_latency", W'(e), W'(D + 3));
        steps('0, 2);

        // Short glitch never reaches acceptance.
        edges_to_valid(10'h004, 3, e);
        edges_to_valid('0, 8, e);
        chk("glitch_no_valid", W'(e), W'(0));

        // Extra key while held is ignored; release clears on edge D+3.
        edges_to_valid(10'h010, 10, e);
        chk("hold_press_latency", W'(e), W'(D + 3));
        steps(10'h011, 5);
        chk("hold_frozen", one_hot_o, 10'h010);
        edges_to_clear(10, e);
        chk("hold_release_latency", W'(e), W'(D + 3));
        steps('0, 2);

        // Two keys at once.
        edges_to_valid(10'h011, 10, e);
`ifdef ONEHOT_CAPTURE_PRIORITY_EN
        chk("multi_priority_valid", W'(e), W'(D + 3));
        chk("multi_priority_code", one_hot_o, 10'h001);
`else
        chk("multi_rejected", W'(e), W'(0));
        chk("multi_no_code", one_hot_o, 10'h000);
`endif
        chk("multi_flag", W'(multi_o), W'(1));
        steps('0, 10);
        chk("multi_cleared", W'(multi_o), W'(0));

        // Bouncing release keeps the code until enough stable zeros.
        steps(10'h002, 10);
        for (int i = 0; i < 6; i++) step((i % 2 == 1) ? 10'h002 : 10'h000);
        chk("bounce_hold", one_hot_o, 10'h002);
        steps('0, 10);

        // Reset in SETTLE, then re-debounce with key still held.
        steps(10'h008, 4);
        do_reset(2);
        edges_to_valid(10'h008, 10, e);
        chk("reset_settle_relatch", W'(e), W'(D + 3));
        // Reset in HOLD.
        steps(10'h008, 3);
        do_reset(2);
        chk("reset_hold_clear", one_hot_o, 10'h000);
        edges_to_valid(10'h008, 10, e);
        chk("reset_hold_relatch", W'(e), W'(D + 3));
        steps('0, 10);

        // Random segments of idle, single keys, multi keys and glitches.
        for (int seg = 0; seg < 120; seg++) begin
            case ($urandom_range(0, 3))
                0:       v = '0;
                1, 2:    v = W'(1) << $urandom_range(0, W - 1);
                default: v = W'($urandom);
            endcase
            steps(v, $urandom_range(1, 2 * D + 4));
            if ($urandom_range(0, 7) == 0) step(W'($urandom));
        end
        steps('0, 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
